sensor_frame_sequencer: RTL

Telemetry scheduler for the sensor register bank. It periodically walks bank addresses 1..25 through the bank's 8-bit address/data read port and packs the returned bytes into a framed byte stream: sync, sequence number, payload and checksum. The stream leaves on a valid/ready handshake toward the radio/UART transmitter. It is the only master of the bank's read port.

---
 rtl/sensor_frame_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sensor_frame_sequencer.sv
// Periodic telemetry framer: walks bank addresses 1..NUM_BYTES and streams
// SYNC0, SYNC1, seq_num, payload, checksum over a valid/ready byte interface.
module sensor_frame_sequencer #(
   parameter int         FRAME_PERIOD = 1000,
   parameter logic [7:0] SYNC0        = 8'hA5,
   parameter logic [7:0] SYNC1        = 8'h5A,
   parameter int         NUM_BYTES    = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       start,
   output logic [7:0] reg_addr,
   input  logic [7:0] reg_data,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       frame_done,
   output logic [7:0] seq_num,
   output logic [7:0] drop_cnt
);

   localparam int             TW         = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
   localparam logic [TW-1:0]  TIMER_LAST = TW'(FRAME_PERIOD - 1);
   localparam logic [7:0]     LAST_ADDR  = 8'(NUM_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC0,
      S_SYNC1,
      S_SEQ,
      S_DATA,
      S_CSUM
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [TW-1:0] r_timer;
   logic [7:0]    r_idx;
   logic [7:0]    r_csum;
   logic [7:0]    r_tx_data;
   logic [7:0]    r_seq;
   logic [7:0]    r_drop;
   logic          r_frame_done;

   logic          w_busy;
   logic          w_tick;
   logic          w_trigger;
   logic          w_accept;
   logic          w_last_data;
   logic          w_load_payload;

   assign w_tick    = enable && (r_timer == TIMER_LAST);
   assign w_trigger = enable && (start || w_tick);
   assign w_accept  = w_busy && tx_ready;
   // r_idx wraps to 0 once the final payload byte is loaded, so idx==0 in DATA
   // marks the last payload byte on the wire.
   assign w_last_data    = (r_state == S_DATA) && (r_idx == 8'd0);
   assign w_load_payload = w_accept && ((r_state == S_SEQ) ||
                                        ((r_state == S_DATA) && !w_last_data));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_trigger)   w_next_state = S_SYNC0;
         S_SYNC0: if (w_accept)    w_next_state = S_SYNC1;
         S_SYNC1: if (w_accept)    w_next_state = S_SEQ;
         S_SEQ:   if (w_accept)    w_next_state = S_DATA;
         S_DATA:  if (w_accept && w_last_data) w_next_state = S_CSUM;
         S_CSUM:  if (w_accept)    w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output logic: a byte is on the wire in every non-idle state
   always_comb begin
      w_busy = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer <= '0;
      end else if (!enable || w_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop <= 8'd0;
      end else if (w_trigger && w_busy && (r_drop != 8'hFF)) begin
         r_drop <= r_drop + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seq        <= 8'd0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_accept && (r_state == S_CSUM);
         if (w_accept && (r_state == S_CSUM)) begin
            r_seq <= r_seq + 8'd1;
         end
      end
   end

   // Byte pipeline: each acceptance loads the next byte of the frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx_data <= 8'd0;
         r_idx     <= 8'd0;
         r_csum    <= 8'd0;
      end else begin
         if ((r_state == S_IDLE) && w_trigger) begin
            r_tx_data <= SYNC0;
            r_idx     <= 8'd1;
            r_csum    <= 8'd0;
         end else if (w_accept) begin
            case (r_state)
               S_SYNC0: r_tx_data <= SYNC1;
               S_SYNC1: begin
                  r_tx_data <= r_seq;
                  r_csum    <= r_csum + r_seq;
               end
               S_DATA: begin
                  if (w_last_data) begin
                     r_tx_data <= r_csum;
                  end
               end
               default: ;
            endcase
            if (w_load_payload) begin
               r_tx_data <= reg_data;
               r_csum    <= r_csum + reg_data;
               r_idx     <= (r_idx == LAST_ADDR) ? 8'd0 : r_idx + 8'd1;
            end
         end
      end
   end

   assign reg_addr   = r_idx;
   assign tx_data    = r_tx_data;
   assign tx_valid   = w_busy;
   assign busy       = w_busy;
   assign frame_done = r_frame_done;
   assign seq_num    = r_seq;
   assign drop_cnt   = r_drop;

endmodule
